reg_file_mp: RTL

REG_FILE_MP -- requirements
Module: reg_file_mp

---
 rtl/rf_pkg.sv | 14 +
 rtl/rf_clear_ctrl.sv | 56 +++++
 rtl/reg_file_mp.sv | 75 +++++++
 3 files changed

// File: rtl/rf_pkg.sv
// Shared types and default sizing for the multi-bank register file.
package rf_pkg;

  typedef enum logic {
    RF_IDLE  = 1'b0,
    RF_CLEAR = 1'b1
  } rf_state_e;

  localparam int RF_W      = 8;
  localparam int RF_D      = 4;
  localparam int RF_NBANK  = 2;
  localparam int RF_BYPASS = 1;

endpackage

// File: rtl/rf_clear_ctrl.sv
// Bank-clear sequencer: walks every register index of one latched bank.
module rf_clear_ctrl
  import rf_pkg::*;
#(
  parameter int D  = RF_D,
  parameter int BW = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear_req,
  input  logic [BW-1:0] bank_sel,
  output logic          busy,
  output logic          clr_en,
  output logic [BW-1:0] clr_bank,
  output logic [D-1:0]  clr_idx
);

  rf_state_e     state, nstate;
  logic [D-1:0]  cnt;
  logic [BW-1:0] bank;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RF_IDLE;
      cnt   <= '0;
      bank  <= '0;
    end else begin
      state <= nstate;
      if (state == RF_IDLE && clear_req) begin
        cnt  <= '0;
        bank <= bank_sel;
      end else if (state == RF_CLEAR) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  always_comb begin
    nstate = state;
    busy   = 1'b0;
    case (state)
      RF_IDLE:  if (clear_req) nstate = RF_CLEAR;
      RF_CLEAR: begin
        busy = 1'b1;
        // last index wraps the counter back to 0 as we leave
        if (cnt == '1) nstate = RF_IDLE;
      end
      default:  nstate = RF_IDLE;
    endcase
  end

  assign clr_en   = busy;
  assign clr_idx  = cnt;
  assign clr_bank = bank;

endmodule

// File: rtl/reg_file_mp.sv
// Banked register file with mover, write forwarding and a sequenced bank clear.
module reg_file_mp
  import rf_pkg::*;
#(
  parameter int W      = RF_W,
  parameter int D      = RF_D,
  parameter int NBANK  = RF_NBANK,
  parameter int BYPASS = RF_BYPASS
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [D-1:0]             wr_num,
  input  logic [W-1:0]             wr_data,
  input  logic                     mov_en,
  input  logic [D-1:0]             rd_num_a,
  input  logic [D-1:0]             rd_num_b,
  output logic [W-1:0]             rd_data_a,
  output logic [W-1:0]             rd_data_b,
  output logic [W-1:0]             acc_out,
  input  logic                     clear_req,
  output logic                     busy,
  input  logic                     bank_swap,
  output logic [$clog2(NBANK)-1:0] bank_sel
);

  localparam int BW   = $clog2(NBANK);
  localparam int NREG = 2 ** D;

  logic [NBANK-1:0][NREG-1:0][W-1:0] mem;
  logic                              wr_fire;
  logic [W-1:0]                      wr_val;
  logic                              clr_en;
  logic [BW-1:0]                     clr_bank;
  logic [D-1:0]                      clr_idx;

  rf_clear_ctrl #(.D(D), .BW(BW)) u_clr (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear_req(clear_req),
    .bank_sel (bank_sel),
    .busy     (busy),
    .clr_en   (clr_en),
    .clr_bank (clr_bank),
    .clr_idx  (clr_idx)
  );

  assign wr_ready = !busy;
  assign wr_fire  = wr_valid && wr_ready;
  assign wr_val   = mov_en ? mem[bank_sel][rd_num_a] : wr_data;

  // Clears and writes never overlap: writes are blocked while busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem <= '0;
    end else begin
      if (clr_en)  mem[clr_bank][clr_idx] <= '0;
      if (wr_fire) mem[bank_sel][wr_num]  <= wr_val;
    end
  end

  // NBANK is a power of two, so the increment wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                bank_sel <= '0;
    else if (bank_swap && !busy) bank_sel <= bank_sel + 1'b1;
  end

  assign rd_data_a = (BYPASS != 0 && wr_fire && rd_num_a == wr_num) ? wr_val
                                                                     : mem[bank_sel][rd_num_a];
  assign rd_data_b = (BYPASS != 0 && wr_fire && rd_num_b == wr_num) ? wr_val
                                                                     : mem[bank_sel][rd_num_b];
  assign acc_out   = mem[bank_sel][0];

endmodule
